mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: the instruction-fetch port and the MEM-stage data port.
- Replaces direct dual-port RAM access in the pipeline top.
- Arbitrates per cycle, returns read data with 1-cycle latency and tags it to the correct requester.
- Raises a stall request to pipe_ctrl whenever a request is not granted.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_WIDTH, 32, address width of both ports and the RAM.
DATA_WIDTH, 32, data width; must be a multiple of 8.
STARVE_LIMIT, 4, max consecutive contended data grants before fetch is forced; range 1..15.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
if_req_i  in  1  fetch read request.
if_addr_i  in  ADDR_WIDTH  fetch address.
if_gnt_o  out  1  fetch granted this cycle (combinational).
if_rvalid_o  out  1  fetch read data valid (registered).
if_rdata_o  out  DATA_WIDTH  fetch read data.
d_req_i  in  1  data request.
d_we_i  in  1  1 = write, 0 = read.
d_be_i  in  DATA_WIDTH/8  byte enables for writes.
d_addr_i  in  ADDR_WIDTH  data address.
d_wdata_i  in  DATA_WIDTH  write data.
d_gnt_o  out  1  data granted this cycle (combinational).
d_rvalid_o  out  1  data read valid (registered).
d_rdata_o  out  DATA_WIDTH  data read data.
ram_ce_o  out  1  RAM enable.
ram_we_o  out  1  RAM write enable.
ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
ram_addr_o  out  ADDR_WIDTH  RAM address.
ram_wdata_o  out  DATA_WIDTH  RAM write data.
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after a read enable.
stallreq_o  out  1  stall request to pipe_ctrl.

Behaviour:
- **Reset (async, rst_i=1):**
  - rd_owner = NONE, starve_cnt = 0, so if_rvalid_o = d_rvalid_o = 0.
  - Grants and ram_ce_o are forced to 0 while rst_i is high.
  - rdata outputs read 0 while rvalid is low.
- **Grant rule (combinational, same cycle as request):**
  - Only if_req_i: if_gnt_o = 1.
  - Only d_req_i: d_gnt_o = 1.
  - Both: d_gnt_o = 1, unless starve_cnt == STARVE_LIMIT, in which case if_gnt_o = 1.
  - At most one grant per cycle.
- **RAM drive:**
  - ram_ce_o = any grant.
  - Fetch grant: ram_we_o = 0, ram_be_o = all ones, ram_addr_o = if_addr_i.
  - Data grant: ram_we_o = d_we_i, ram_be_o = d_be_i, ram_addr_o = d_addr_i, ram_wdata_o = d_wdata_i.
  - No grant: ram_we_o = 0, and ram_be_o, ram_addr_o and ram_wdata_o are all 0.
  - Addresses pass through unmodified.
- **rd_owner state machine** (register; values NONE / IF / DATA), at each rising edge:
  - Fetch granted → IF.
  - Data read granted → DATA.
  - Otherwise (write or no grant) → NONE.
- **Read return (1-cycle latency):**
  - if_rvalid_o = (rd_owner == IF); d_rvalid_o = (rd_owner == DATA).
  - The valid port's rdata = ram_rdata_i; the other port's rdata = 0.
  - Writes never produce rvalid.
  - Back-to-back reads are fully pipelined: one grant per cycle, no bubble.
- **Starvation counter** (4-bit, at each rising edge):
  - if_req_i && d_gnt_o → increment, saturating at STARVE_LIMIT.
  - if_gnt_o or !if_req_i → 0.
- **Stall request:** stallreq_o = (if_req_i && !if_gnt_o) || (d_req_i && !d_gnt_o); combinational.
- **Requester contract:** a requester holds req, addr, we, be and wdata stable until it sees gnt. The arbiter has no buffering.
- **Reset mid-operation:** an outstanding read is discarded; no rvalid is issued after reset deasserts.
- **Design assumptions:** the RAM must be single-port and read-first with a 1-cycle read latency; no combinational path from ram_rdata_i to any grant.

Test Plan:
1. **Fetch only:** RAM preloaded [0x0] = 0x00500093, [0x4] = 0x00100113; if_req_i = 1 at 0x0 then 0x4 on consecutive cycles → if_gnt_o = 1 both cycles; if_rvalid_o = 1 on the next two cycles with those words; stallreq_o = 0 throughout.
2. **Contention, data read:** both request; d_addr_i = 0x100 (holds 0xDEADBEEF) → d_gnt_o = 1, if_gnt_o = 0, stallreq_o = 1. Next cycle d_rvalid_o = 1 with d_rdata_o = 0xDEADBEEF. Data drops its request → if_gnt_o = 1 that cycle.
3. **Starvation:** STARVE_LIMIT = 4, d_req_i with writes and if_req_i both held high → d_gnt_o for cycles 1–4, if_gnt_o on cycle 5, d_gnt_o on cycle 6, and the pattern repeats with a period of 5.
4. **Byte write:** [0x200] = 0x11223344; write d_be_i = 4'b0011, d_wdata_i = 0xAABBCCDD → d_rvalid_o stays 0. A later read of 0x200 returns 0x1122CCDD.
5. **Reset mid-read:** assert rst_i in the cycle after a granted fetch read → if_rvalid_o = 0, all grants = 0 and starve_cnt = 0 immediately. After release, no stale rvalid appears.
6. **Idle:** no requests → ram_ce_o = 0, ram_we_o = 0, stallreq_o = 0, both rvalid = 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the fetch port, the data port, the RAM port and the
//               stall request of mem_port_arbiter into one interface.
//               The requesters and the RAM connect through the 'master'
//               modport. The arbiter connects through the 'slave' modport.
// Signals     : if_*   fetch requester (read only)
//               d_*    data requester (read / byte-enabled write)
//               ram_*  single-port synchronous RAM, 1-cycle read latency
//               stallreq_o  stall request towards pipe_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // fetch port
  logic                    if_req_i;
  logic [ADDR_WIDTH-1:0]   if_addr_i;
  logic                    if_gnt_o;
  logic                    if_rvalid_o;
  logic [DATA_WIDTH-1:0]   if_rdata_o;

  // data port
  logic                    d_req_i;
  logic                    d_we_i;
  logic [DATA_WIDTH/8-1:0] d_be_i;
  logic [ADDR_WIDTH-1:0]   d_addr_i;
  logic [DATA_WIDTH-1:0]   d_wdata_i;
  logic                    d_gnt_o;
  logic                    d_rvalid_o;
  logic [DATA_WIDTH-1:0]   d_rdata_o;

  // RAM port
  logic                    ram_ce_o;
  logic                    ram_we_o;
  logic [DATA_WIDTH/8-1:0] ram_be_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;

  // pipeline control
  logic                    stallreq_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  ram_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output ram_ce_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output stallreq_o
  );

  // Requester / RAM side
  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output ram_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  ram_ce_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  stallreq_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous RAM between the
//               instruction-fetch port and the MEM-stage data port.
//               - Grants are combinational. At most one requester is
//                 granted per cycle.
//               - The data port has priority. After STARVE_LIMIT consecutive
//                 data grants made while fetch was waiting, fetch is forced.
//               - Read data returns one cycle after the grant. It is steered
//                 to its owner by the registered rd_owner state.
//               - stallreq_o is raised whenever a request goes ungranted.
// Ports       : clk_i, rst_i   clock (rising edge); async active-high reset
//               bus (slave)    fetch/data requesters, RAM port, stallreq_o
// Parameters  : ADDR_WIDTH     address width of both ports and the RAM
//               DATA_WIDTH     data width, must be a multiple of 8
//               STARVE_LIMIT   forced-fetch threshold, 1..15
// Assumes     : the RAM is single-port, read-first, 1-cycle read latency
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_port_arbiter_if.slave    bus
);

  localparam int                  c_BE_WIDTH     = DATA_WIDTH / 8;
  localparam logic [c_BE_WIDTH-1:0] c_BE_ALL     = {c_BE_WIDTH{1'b1}};
  localparam logic [3:0]          c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  // Owner of the read that is in flight in the RAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DATA = 2'b10
  } owner_t;

  owner_t     r_owner;
  owner_t     w_owner_next;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_next;

  logic       w_fetch_forced;
  logic       w_if_gnt;
  logic       w_d_gnt;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_owner      <= w_owner_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // The grants depend only on the requests and the starvation counter. They
  // never depend on ram_rdata_i, so there is no RAM-to-grant timing path.
  // Grants are held low during reset so that nothing reaches the RAM.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch_forced = (r_starve_cnt == c_STARVE_LIMIT);
    w_if_gnt       = 1'b0;
    w_d_gnt        = 1'b0;
    if (!rst_i) begin
      if (bus.d_req_i && !(bus.if_req_i && w_fetch_forced)) begin
        w_d_gnt = 1'b1;
      end else if (bus.if_req_i) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state: read ownership and starvation count
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_next  = OWN_NONE;
    w_starve_next = 4'd0;

    // A write occupies the RAM but returns nothing, so it leaves no owner
    if (w_if_gnt) begin
      w_owner_next = OWN_IF;
    end else if (w_d_gnt && !bus.d_we_i) begin
      w_owner_next = OWN_DATA;
    end

    // Count data grants that were taken while fetch was waiting. Any fetch
    // grant, or an idle fetch port, clears the count.
    if (bus.if_req_i && w_d_gnt) begin
      if (r_starve_cnt >= c_STARVE_LIMIT) begin
        w_starve_next = c_STARVE_LIMIT;
      end else begin
        w_starve_next = r_starve_cnt + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM drive: steer the winner's request onto the RAM. An idle RAM port is
  // driven to all zeros.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.ram_ce_o    = w_if_gnt | w_d_gnt;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = '0;
    bus.ram_addr_o  = {ADDR_WIDTH{1'b0}};
    bus.ram_wdata_o = {DATA_WIDTH{1'b0}};
    if (w_if_gnt) begin
      bus.ram_be_o   = c_BE_ALL;
      bus.ram_addr_o = bus.if_addr_i;
    end else if (w_d_gnt) begin
      bus.ram_we_o    = bus.d_we_i;
      bus.ram_be_o    = bus.d_be_i;
      bus.ram_addr_o  = bus.d_addr_i;
      bus.ram_wdata_o = bus.d_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Read return: the RAM output is valid in the cycle after the grant. It is
  // handed only to the port recorded in r_owner. The other port sees zero.
  // --------------------------------------------------------------------------
  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.d_gnt_o     = w_d_gnt;

  assign bus.if_rvalid_o = (r_owner == OWN_IF);
  assign bus.d_rvalid_o  = (r_owner == OWN_DATA);
  assign bus.if_rdata_o  = (r_owner == OWN_IF)   ? bus.ram_rdata_i : {DATA_WIDTH{1'b0}};
  assign bus.d_rdata_o   = (r_owner == OWN_DATA) ? bus.ram_rdata_i : {DATA_WIDTH{1'b0}};

  assign bus.stallreq_o  = (bus.if_req_i && !w_if_gnt) || (bus.d_req_i && !w_d_gnt);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Testbench for mem_port_arbiter. Includes a behavioural
//               single-port read-first RAM, a golden memory with arbitration
//               reference, a scoreboard of per-cycle expectations and
//               read-data queues, and a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0050_0093;
      1:       return 32'h0010_0113;
      64:      return 32'hDEAD_BEEF;   // 0x100
      128:     return 32'h1122_3344;   // 0x200
      default: return 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B9);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < BW; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    return w;
  endfunction

  function automatic logic [31:0] pick_addr();
    int idx;
    case ($urandom_range(0, 3))
      0, 1:    idx = $urandom_range(0, 15);
      2:       idx = ($urandom_range(0, 1) == 0) ? 64 : 128;
      default: idx = 192 + $urandom_range(0, 7);
    endcase
    return 32'(idx) << 2;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ------------------------------------------------------ behavioural RAM
  logic [31:0] ram_mem [0:255];
  logic [31:0] ram_q;
  assign bus.ram_rdata_i = ram_q;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
    ram_q = '0;
  end

  always @(posedge clk) begin
    if (bus.ram_ce_o) begin
      if (bus.ram_we_o)
        ram_mem[bus.ram_addr_o[9:2]] <= merge(ram_mem[bus.ram_addr_o[9:2]],
                                              bus.ram_wdata_o, bus.ram_be_o);
      else
        ram_q <= ram_mem[bus.ram_addr_o[9:2]];
    end
  end

  // ------------------------------------------------------ reference model
  typedef struct {
    bit          if_gnt, d_gnt, stall, ce, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    bit          chk_wdata;
    bit          if_rv, d_rv;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] gold [0:255];
  int          m_wait;      // consecutive data wins while fetch waited
  bit          m_rd_if, m_rd_d;

  task automatic model_reset();
    m_wait  = 0;
    m_rd_if = 1'b0;
    m_rd_d  = 1'b0;
    cyc_q.delete();
    if_q.delete();
    d_q.delete();
  endtask

  // Apply one cycle of requests and record the expected response.
  task automatic drive_cycle(input bit ir, input logic [31:0] ia,
                             input bit dr, input bit dwe, input logic [3:0] dbe,
                             input logic [31:0] da, input logic [31:0] dwd,
                             output bit ig, output bit dg);
    exp_t e;
    bit   forced;
    @(posedge clk);
    #1;
    bus.if_req_i  = ir;
    bus.if_addr_i = ia;
    bus.d_req_i   = dr;
    bus.d_we_i    = dwe;
    bus.d_be_i    = dbe;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dwd;

    e.if_rv = m_rd_if;
    e.d_rv  = m_rd_d;

    forced = ir && dr && (m_wait == SL);
    ig = ir && (!dr || forced);
    dg = dr && !ig;

    e.if_gnt    = ig;
    e.d_gnt     = dg;
    e.stall     = (ir && !ig) || (dr && !dg);
    e.ce        = ig || dg;
    e.we        = dg && dwe;
    e.be        = ig ? 4'hF : (dg ? dbe : 4'h0);
    e.addr      = ig ? ia : (dg ? da : 32'h0);
    e.chk_wdata = !ig;
    e.wdata     = dg ? dwd : 32'h0;

    if (ig) if_q.push_back(gold[ia[9:2]]);
    if (dg && !dwe) d_q.push_back(gold[da[9:2]]);
    if (dg && dwe) gold[da[9:2]] = merge(gold[da[9:2]], dwd, dbe);

    m_rd_if = ig;
    m_rd_d  = dg && !dwe;
    m_wait  = (ir && dg) ? ((m_wait < SL) ? m_wait + 1 : SL) : 0;
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit ig, dg;
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 0, 0, 0, 0, ig, dg);
  endtask

  // Requesters obeying the hold-until-granted contract
  task automatic run_random(input int n, input int p_if, input int p_d, input int p_we);
    bit ip, dp, dwe, ig, dg;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dbe = 0; dwe = 0;
    for (int c = 0; c < n; c++) begin
      if (!ip && $urandom_range(0, 99) < p_if) begin
        ip = 1; ia = pick_addr();
      end
      if (!dp && $urandom_range(0, 99) < p_d) begin
        dp  = 1;
        dwe = ($urandom_range(0, 99) < p_we);
        dbe = 4'($urandom);
        da  = pick_addr();
        dwd = $urandom;
      end
      drive_cycle(ip, ia, dp, dwe, dbe, da, dwd, ig, dg);
      if (ig) ip = 0;
      if (dg) dp = 0;
    end
  endtask

  // --------------------------------------------------------------- monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      chk("if_gnt",   bus.if_gnt_o,   mon_e.if_gnt);
      chk("d_gnt",    bus.d_gnt_o,    mon_e.d_gnt);
      chk("stallreq", bus.stallreq_o, mon_e.stall);
      chk("ram_ce",   bus.ram_ce_o,   mon_e.ce);
      chk("ram_we",   bus.ram_we_o,   mon_e.we);
      chk("ram_be",   bus.ram_be_o,   mon_e.be);
      chk("ram_addr", bus.ram_addr_o, mon_e.addr);
      if (mon_e.chk_wdata) chk("ram_wdata", bus.ram_wdata_o, mon_e.wdata);
      chk("if_rvalid", bus.if_rvalid_o, mon_e.if_rv);
      chk("d_rvalid",  bus.d_rvalid_o,  mon_e.d_rv);
      if (mon_e.if_rv) begin
        if (if_q.size() == 0) chk("if_rdata_queue", 64'd0, 64'd1);
        else                  chk("if_rdata", bus.if_rdata_o, if_q.pop_front());
      end else begin
        chk("if_rdata_idle", bus.if_rdata_o, 32'h0);
      end
      if (mon_e.d_rv) begin
        if (d_q.size() == 0) chk("d_rdata_queue", 64'd0, 64'd1);
        else                 chk("d_rdata", bus.d_rdata_o, d_q.pop_front());
      end else begin
        chk("d_rdata_idle", bus.d_rdata_o, 32'h0);
      end
    end
  end

  // -------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ------------------------------------------------------------- stimulus
  initial begin : main
    bit ig, dg;
    for (int i = 0; i < 256; i++) gold[i] = init_word(i);
    model_reset();

    // Reset state: both requesting while reset is high
    bus.if_req_i  = 1;  bus.if_addr_i = 32'h0;
    bus.d_req_i   = 1;  bus.d_we_i    = 0;
    bus.d_be_i    = 4'hF; bus.d_addr_i = 32'h100; bus.d_wdata_i = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_if_gnt",    bus.if_gnt_o,    0);
    chk("rst_d_gnt",     bus.d_gnt_o,     0);
    chk("rst_ram_ce",    bus.ram_ce_o,    0);
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);
    chk("rst_d_rvalid",  bus.d_rvalid_o,  0);
    chk("rst_if_rdata",  bus.if_rdata_o,  0);
    chk("rst_d_rdata",   bus.d_rdata_o,   0);
    bus.if_req_i = 0;
    bus.d_req_i  = 0;
    rst    = 0;
    mon_en = 1;

    // Fetch only, back-to-back
    drive_cycle(1, 32'h0, 0, 0, 0, 0, 0, ig, dg);
    drive_cycle(1, 32'h4, 0, 0, 0, 0, 0, ig, dg);
    idle(2);

    // Contention on a data read, then data withdraws
    drive_cycle(1, 32'h8, 1, 0, 4'hF, 32'h100, 0, ig, dg);
    drive_cycle(1, 32'h8, 0, 0, 0, 0, 0, ig, dg);
    idle(1);

    // Byte write then read back
    drive_cycle(0, 0, 1, 1, 4'b0011, 32'h200, 32'hAABB_CCDD, ig, dg);
    drive_cycle(0, 0, 1, 0, 4'hF, 32'h200, 0, ig, dg);
    idle(3);

    // Starvation: both ports always requesting, data writing
    run_random(17, 100, 100, 100);
    idle(1);

    // Reset during an outstanding fetch read
    drive_cycle(1, 32'h0, 0, 0, 0, 0, 0, ig, dg);
    @(posedge clk);
    #1;
    mon_en = 0;
    bus.if_req_i = 1; bus.if_addr_i = 32'h4;
    bus.d_req_i  = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h100;
    rst = 1;
    #1;
    chk("midrst_if_rvalid", bus.if_rvalid_o, 0);
    chk("midrst_if_rdata",  bus.if_rdata_o,  0);
    chk("midrst_if_gnt",    bus.if_gnt_o,    0);
    chk("midrst_d_gnt",     bus.d_gnt_o,     0);
    chk("midrst_ram_ce",    bus.ram_ce_o,    0);
    @(posedge clk);
    #1;
    chk("midrst_hold_if_rvalid", bus.if_rvalid_o, 0);
    chk("midrst_hold_d_rvalid",  bus.d_rvalid_o,  0);
    model_reset();
    bus.if_req_i = 0;
    bus.d_req_i  = 0;
    rst    = 0;
    mon_en = 1;
    idle(2);
    // Fresh counter after reset: four data wins before fetch is forced
    run_random(12, 100, 100, 100);
    idle(1);

    // Randomised traffic
    run_random(300, 60, 60, 40);
    run_random(100, 90, 90, 50);
    idle(3);

    @(negedge clk);
    #1;
    chk("queues_drained", 64'(if_q.size() + d_q.size() + cyc_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
